adc_serial_sampler: RTL and testbench
=====================================

Name: adc_serial_sampler

Overview:
- Upstream acquisition stage for the temperature calculator.
- Drives an external serial (SPI-style, read-only) 16-bit temperature-sensor ADC.
- Deserialises each conversion and averages 2^AVG_LOG2 consecutive samples.
- Presents the result on adc_data with a one-cycle adc_valid strobe. adc_data is held stable between updates so the combinational temperature calculator can consume it directly.

Parameters:
DATA_W, 16, width of one ADC sample and of adc_data
CLK_DIV, 4, clk cycles per sclk half-period (sclk period = 2*CLK_DIV clk cycles); must be >= 1
CONV_WAIT, 8, clk cycles spent in CONVERT (conversion time) before shifting; must be >= 1
AVG_LOG2, 2, log2 of samples averaged per output (0 = no averaging)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  level; high = acquire continuously
adc_sdo  in  1  serial data from ADC, MSB first
adc_convst  out  1  conversion-start pulse to ADC
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  serial clock to ADC
adc_data  out  DATA_W  averaged sample, feeds temperature calculator adc_data
adc_valid  out  1  one-cycle strobe, adc_data updated this cycle
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): all of the following are forced regardless of clk.
  - adc_cs_n=1, adc_sclk=0, adc_convst=0, adc_data=0, adc_valid=0, busy=0.
  - Accumulator, sample count, bit count and divider are cleared; state=IDLE.
- Reset mid-frame aborts the transfer instantly.
- All outputs are registered.
- States: IDLE, CONVERT, SHIFT, ACCUM, OUTPUT.
- IDLE: cs_n=1, sclk=0. On the edge where enable=1, go to CONVERT.
- CONVERT: lasts exactly CONV_WAIT cycles. adc_convst=1 in the first cycle only; cs_n=1. Then go to SHIFT.
- SHIFT:
  - cs_n=0 for exactly 2*DATA_W*CLK_DIV cycles. sclk starts low and toggles every CLK_DIV cycles, giving exactly DATA_W rising edges.
  - adc_sdo is captured on the clk edge that drives sclk 0->1 and shifted in MSB first.
  - The frame ends with sclk low; cs_n returns to 1 as the state leaves SHIFT. Then go to ACCUM.
- ACCUM (1 cycle):
  - acc += sample. acc is DATA_W+AVG_LOG2 bits and never overflows.
  - If enable=0: discard acc/count and go to IDLE. No valid is produced and adc_data keeps its last value.
  - Else if count == 2^AVG_LOG2-1: go to OUTPUT.
  - Else count++ and go to CONVERT.
- OUTPUT (1 cycle):
  - adc_data <= acc >> AVG_LOG2 (truncate, no rounding); adc_valid=1 this cycle only.
  - acc and count are cleared.
  - Next state is CONVERT if enable=1, else IDLE.
- enable falling during CONVERT or SHIFT: the current frame always completes (ADC protocol is never broken mid-frame). Abort is taken at ACCUM.
- Latency, defaults, with enable seen high at edge 0:
  - Per sample: CONV_WAIT + 2*DATA_W*CLK_DIV + 1 = 137 cycles.
  - CONVERT occupies cycles 1-8, SHIFT 9-136, ACCUM 137.
  - adc_valid is high in cycle 4*137+1 = 549.
  - With enable held, subsequent valids follow every 4*137+1 = 549 cycles.
- enable toggling while IDLE with no edge high: no activity.
- adc_sdo is ignored outside sclk rising edges in SHIFT.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs immediately at reset values (cs_n=1, sclk=0, convst=0, adc_data=0, valid=0, busy=0).
- Steady average: ADC model returns 0x3081 for four frames, enable held from edge 0 -> adc_valid single-cycle pulse at cycle 549 with adc_data=0x3081; next pulse at cycle 1098.
- Frame timing: per frame, convst high exactly 1 cycle; cs_n low for 128 cycles; sclk period 8 cycles; exactly 16 sclk rising edges; sclk low when cs_n rises.
- Truncation and extremes:
  - Samples 0x0001, 0x0002, 0x0002, 0x0002 (sum 7) -> adc_data=0x0001.
  - Four samples of 0xFFFF -> adc_data=0xFFFF.
  - Four samples of 0x0000 -> adc_data=0x0000.
- Enable drop: after one valid of 0x3081, drop enable during SHIFT of sample 2 -> frame still completes 16 sclk edges, cs_n rises, no adc_valid, busy falls after ACCUM, adc_data stays 0x3081.
- Reset mid-SHIFT, then re-enable with samples 0x0100 x4 -> cs_n=1 and sclk=0 immediately on rst; fresh average yields adc_data=0x0100 at cycle 549 after re-enable (no stale partial sum).

Source files
------------

// File: rtl/adc_serial_sampler_if.sv
// ---------------------------------------------------------------------------
// adc_serial_sampler_if
//
// Purpose: bundles the signals of the ADC acquisition block. It carries the
// serial link to the external read-only temperature-sensor ADC, the averaged
// sample handed to the temperature calculator, and the status/control level
// signals.
//
// Signals:
//   enable     : level, high = acquire continuously        (env -> sampler)
//   adc_sdo    : serial data from the ADC, MSB first        (ADC -> sampler)
//   adc_convst : conversion-start pulse to the ADC          (sampler -> ADC)
//   adc_cs_n   : ADC chip select, active low                (sampler -> ADC)
//   adc_sclk   : serial clock to the ADC                    (sampler -> ADC)
//   adc_data   : averaged sample, held between updates      (sampler -> env)
//   adc_valid  : one-cycle strobe, adc_data updated         (sampler -> env)
//   busy       : high whenever the sampler is not idle      (sampler -> env)
//
// Modports:
//   master : the sampler itself (drives the ADC link and the result)
//   slave  : the surrounding environment (ADC device and consumer)
// ---------------------------------------------------------------------------
interface adc_serial_sampler_if #(
    parameter int DATA_W = 16
) ();

    logic              enable;
    logic              adc_sdo;
    logic              adc_convst;
    logic              adc_cs_n;
    logic              adc_sclk;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              busy;

    modport master (
        input  enable,
        input  adc_sdo,
        output adc_convst,
        output adc_cs_n,
        output adc_sclk,
        output adc_data,
        output adc_valid,
        output busy
    );

    modport slave (
        output enable,
        output adc_sdo,
        input  adc_convst,
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_data,
        input  adc_valid,
        input  busy
    );

endinterface

// File: rtl/adc_serial_sampler.sv
// ---------------------------------------------------------------------------
// adc_serial_sampler
//
// Purpose: upstream acquisition stage for the temperature calculator. Drives
// an external SPI-style, read-only ADC: pulses convst, waits the conversion
// time, clocks out one DATA_W-bit frame MSB first, and averages 2^AVG_LOG2
// consecutive samples. The truncated average is presented on adc_data with a
// one-cycle adc_valid strobe; adc_data is held between updates so that a
// combinational consumer can use it directly.
//
// Parameters:
//   DATA_W    : width of one ADC sample and of adc_data
//   CLK_DIV   : clk cycles per sclk half-period (>= 1)
//   CONV_WAIT : clk cycles spent in CONVERT before shifting (>= 1)
//   AVG_LOG2  : log2 of the number of samples averaged (0 = no averaging)
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset; aborts any frame immediately
//   bus : adc_serial_sampler_if.master (enable, adc_sdo in; adc_convst,
//         adc_cs_n, adc_sclk, adc_data, adc_valid, busy out)
//
// All outputs come straight from registers. Each register is loaded on the
// same edge that moves the FSM into the state the output belongs to, so the
// outputs line up cycle-for-cycle with the state.
// ---------------------------------------------------------------------------
module adc_serial_sampler #(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 4,
    parameter int CONV_WAIT = 8,
    parameter int AVG_LOG2  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    adc_serial_sampler_if.master    bus
);

    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNV_W  = (CONV_WAIT > 1) ? $clog2(CONV_WAIT) : 1;
    localparam int HALF_W = $clog2(2 * DATA_W);
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNV_W-1:0]  CONV_LAST = CNV_W'(CONV_WAIT - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((2 ** AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SHIFT,
        ACCUM,
        OUTPUT
    } state_t;

    state_t              state_q;
    logic [CNV_W-1:0]    conv_cnt_q;
    logic [DIV_W-1:0]    div_q;
    logic [HALF_W-1:0]   half_q;
    logic [DATA_W-1:0]   shift_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                convst_q;
    logic                cs_n_q;
    logic                sclk_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                busy_q;

    // Running sum including the sample that has just been shifted in.
    logic [ACC_W-1:0]    acc_sum_d;

    // Divide by 2^AVG_LOG2 with plain truncation (no rounding). The
    // accumulator is wide enough that the quotient always fits DATA_W.
    function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        return DATA_W'(sum >> AVG_LOG2);
    endfunction

    assign acc_sum_d = acc_q + ACC_W'(shift_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            conv_cnt_q <= '0;
            div_q      <= '0;
            half_q     <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            convst_q   <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Both strobes are single-cycle; only a state entry re-arms them.
            convst_q <= 1'b0;
            valid_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        state_q    <= CONVERT;
                        conv_cnt_q <= '0;
                        convst_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end

                CONVERT: begin
                    if (conv_cnt_q == CONV_LAST) begin
                        state_q <= SHIFT;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        div_q   <= '0;
                        half_q  <= '0;
                    end else begin
                        conv_cnt_q <= conv_cnt_q + CNV_W'(1);
                    end
                end

                SHIFT: begin
                    // half_q counts sclk half-periods; even halves are low,
                    // odd halves high, so there are DATA_W rising edges.
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        // The edge that raises sclk also samples adc_sdo.
                        if (!sclk_q) begin
                            shift_q <= {shift_q[DATA_W-2:0], bus.adc_sdo};
                        end
                        if (half_q == HALF_LAST) begin
                            // Last falling sclk coincides with cs_n release.
                            state_q <= ACCUM;
                            cs_n_q  <= 1'b1;
                            sclk_q  <= 1'b0;
                        end else begin
                            sclk_q <= ~sclk_q;
                            half_q <= half_q + HALF_W'(1);
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                ACCUM: begin
                    // enable is only honoured here so a frame is never cut.
                    if (!bus.enable) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= OUTPUT;
                        acc_q   <= acc_sum_d;
                        data_q  <= avg_trunc(acc_sum_d);
                        valid_q <= 1'b1;
                    end else begin
                        state_q    <= CONVERT;
                        acc_q      <= acc_sum_d;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        conv_cnt_q <= '0;
                        convst_q   <= 1'b1;
                    end
                end

                OUTPUT: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (bus.enable) begin
                        state_q    <= CONVERT;
                        conv_cnt_q <= '0;
                        convst_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.adc_convst = convst_q;
    assign bus.adc_cs_n   = cs_n_q;
    assign bus.adc_sclk   = sclk_q;
    assign bus.adc_data   = data_q;
    assign bus.adc_valid  = valid_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_adc_serial_sampler.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_sampler
//
// Directed bench for adc_serial_sampler with the default parameters. A small
// behavioural ADC returns queued words (or a default word) MSB first, moving
// to the next bit on each falling sclk. A monitor gathers per-frame timing
// and adc_valid events; the single initial block drives directed steps and
// compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_adc_serial_sampler;

    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    adc_serial_sampler_if #(.DATA_W(DATA_W)) bus ();

    adc_serial_sampler #(
        .DATA_W   (DATA_W),
        .CLK_DIV  (4),
        .CONV_WAIT(8),
        .AVG_LOG2 (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- cycle counting ----------------
    int edge_n = 0;
    int base   = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- ADC model ----------------
    logic [15:0] word_tab [0:63];
    int          wr_ptr       = 0;
    int          rd_ptr       = 0;
    logic [15:0] default_word = 16'h3081;
    logic [15:0] cur_word     = 16'h0000;
    int          bit_idx      = 0;
    logic        m_cs_prev    = 1'b1;
    logic        m_sclk_prev  = 1'b0;

    initial bus.adc_sdo = 1'b0;

    always @(bus.adc_cs_n or bus.adc_sclk) begin
        if (!bus.adc_cs_n && m_cs_prev) begin
            if (rd_ptr < wr_ptr) begin
                cur_word = word_tab[rd_ptr];
                rd_ptr   = rd_ptr + 1;
            end else begin
                cur_word = default_word;
            end
            bit_idx     = 15;
            bus.adc_sdo = cur_word[15];
        end else if (!bus.adc_cs_n && !bus.adc_sclk && m_sclk_prev && bit_idx > 0) begin
            bit_idx     = bit_idx - 1;
            bus.adc_sdo = cur_word[bit_idx];
        end
        m_cs_prev   = bus.adc_cs_n;
        m_sclk_prev = bus.adc_sclk;
    end

    // ---------------- monitor ----------------
    logic prev_cs    = 1'b1;
    logic prev_sclk  = 1'b0;
    logic prev_valid = 1'b0;
    int   conv_hi = 0, cs_low = 0, rises = 0;
    int   pmin = 999, pmax = 0, last_rise = 0;
    logic last_rise_ok = 1'b0;
    int   f_conv = 0, f_cslow = 0, f_rises = 0, f_pmin = 0, f_pmax = 0;
    logic f_sclk = 1'b0;
    int   frames = 0;
    int   valid_cnt = 0, last_valid_cyc = 0, double_cnt = 0;
    logic [15:0] last_valid_data = 16'h0;

    always @(negedge clk) begin
        prev_cs    <= bus.adc_cs_n;
        prev_sclk  <= bus.adc_sclk;
        prev_valid <= bus.adc_valid;
        if (bus.adc_convst) conv_hi <= conv_hi + 1;
        if (!bus.adc_cs_n) cs_low <= cs_low + 1;
        if (bus.adc_sclk && !prev_sclk && !bus.adc_cs_n) begin
            rises        <= rises + 1;
            last_rise    <= edge_n;
            last_rise_ok <= 1'b1;
            if (last_rise_ok && (edge_n - last_rise) < pmin) pmin <= edge_n - last_rise;
            if (last_rise_ok && (edge_n - last_rise) > pmax) pmax <= edge_n - last_rise;
        end
        if (bus.adc_cs_n && !prev_cs) begin
            f_conv       <= conv_hi;
            f_cslow      <= cs_low;
            f_rises      <= rises;
            f_pmin       <= pmin;
            f_pmax       <= pmax;
            f_sclk       <= bus.adc_sclk;
            frames       <= frames + 1;
            conv_hi      <= 0;
            cs_low       <= 0;
            rises        <= 0;
            pmin         <= 999;
            pmax         <= 0;
            last_rise_ok <= 1'b0;
        end
        if (bus.adc_valid) begin
            valid_cnt       <= valid_cnt + 1;
            last_valid_cyc  <= edge_n - base;
            last_valid_data <= bus.adc_data;
            if (prev_valid) double_cnt <= double_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        word_tab[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic start_enable();
        bus.enable = 1'b1;
        base = edge_n;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && bus.busy !== 1'b0; i++) tick();
        chk(tag, bus.busy, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    int v0;
    int f0;
    logic [15:0] exp_avg [0:2];

    initial begin
        bus.enable = 1'b0;

        // Reset asserted mid-cycle, outputs checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_cs_n",   bus.adc_cs_n,   1'b1);
        chk("rst_sclk",   bus.adc_sclk,   1'b0);
        chk("rst_convst", bus.adc_convst, 1'b0);
        chk("rst_data",   bus.adc_data,   16'h0000);
        chk("rst_valid",  bus.adc_valid,  1'b0);
        chk("rst_busy",   bus.busy,       1'b0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // enable pulse that never reaches a clock edge.
        bus.enable = 1'b1;
        #2 bus.enable = 1'b0;
        repeat (5) tick();
        chk("glitch_busy",   bus.busy, 1'b0);
        chk("glitch_convst", conv_hi,  0);
        chk("glitch_frames", frames,   0);

        // Steady average of 0x3081, two consecutive results.
        default_word = 16'h3081;
        v0 = valid_cnt;
        start_enable();
        for (int i = 0; i < 1300 && valid_cnt == v0; i++) tick();
        chk("steady_v1_seen",   valid_cnt,       v0 + 1);
        chk("steady_v1_cycle",  last_valid_cyc,  549);
        chk("steady_v1_data",   last_valid_data, 16'h3081);
        chk("steady_v1_strobe", bus.adc_valid,   1'b1);
        tick();
        chk("steady_v1_single", bus.adc_valid,   1'b0);
        chk("steady_v1_hold",   bus.adc_data,    16'h3081);
        for (int i = 0; i < 700 && valid_cnt == v0 + 1; i++) tick();
        chk("steady_v2_seen",   valid_cnt,       v0 + 2);
        chk("steady_v2_cycle",  last_valid_cyc,  1098);
        chk("steady_v2_data",   last_valid_data, 16'h3081);
        chk("frame_convst_len", f_conv,  1);
        chk("frame_cs_low_len", f_cslow, 128);
        chk("frame_sclk_rises", f_rises, 16);
        chk("frame_sclk_pmin",  f_pmin,  8);
        chk("frame_sclk_pmax",  f_pmax,  8);
        chk("frame_sclk_at_cs", f_sclk,  1'b0);
        bus.enable = 1'b0;
        wait_idle("steady_idle");
        chk("steady_no_extra_valid", valid_cnt, v0 + 2);

        // Truncation and extremes, three averages back to back.
        push_word(16'h0001); push_word(16'h0002); push_word(16'h0002); push_word(16'h0002);
        for (int k = 0; k < 4; k++) push_word(16'hFFFF);
        for (int k = 0; k < 4; k++) push_word(16'h0000);
        exp_avg[0] = 16'h0001;
        exp_avg[1] = 16'hFFFF;
        exp_avg[2] = 16'h0000;
        v0 = valid_cnt;
        start_enable();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 1300 && valid_cnt == v0 + k; i++) tick();
            chk($sformatf("avg%0d_seen", k),  valid_cnt,       v0 + k + 1);
            chk($sformatf("avg%0d_cycle", k), last_valid_cyc,  549 * (k + 1));
            chk($sformatf("avg%0d_data", k),  last_valid_data, exp_avg[k]);
        end
        bus.enable = 1'b0;
        wait_idle("avg_idle");

        // enable dropped in the middle of a frame after one result.
        default_word = 16'h3081;
        v0 = valid_cnt;
        start_enable();
        for (int i = 0; i < 1300 && valid_cnt == v0; i++) tick();
        chk("drop_v1_data", last_valid_data, 16'h3081);
        for (int i = 0; i < 200 && bus.adc_cs_n !== 1'b0; i++) tick();
        chk("drop_in_shift", bus.adc_cs_n, 1'b0);
        repeat (20) tick();
        f0 = frames;
        bus.enable = 1'b0;
        wait_idle("drop_busy_fall");
        chk("drop_frame_done",  frames,       f0 + 1);
        chk("drop_frame_rises", f_rises,      16);
        chk("drop_frame_cslow", f_cslow,      128);
        chk("drop_frame_sclk",  f_sclk,       1'b0);
        chk("drop_cs_n_high",   bus.adc_cs_n, 1'b1);
        chk("drop_no_valid",    valid_cnt,    v0 + 1);
        chk("drop_data_hold",   bus.adc_data, 16'h3081);

        // Reset during the second frame of an average, then a fresh run.
        start_enable();
        f0 = frames;
        for (int i = 0; i < 300 && frames == f0; i++) tick();
        for (int i = 0; i < 300 && bus.adc_sclk !== 1'b1; i++) tick();
        chk("mid_rst_in_shift", bus.adc_cs_n, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_cs_n",   bus.adc_cs_n,   1'b1);
        chk("mid_rst_sclk",   bus.adc_sclk,   1'b0);
        chk("mid_rst_convst", bus.adc_convst, 1'b0);
        chk("mid_rst_busy",   bus.busy,       1'b0);
        chk("mid_rst_valid",  bus.adc_valid,  1'b0);
        chk("mid_rst_data",   bus.adc_data,   16'h0000);
        bus.enable = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) push_word(16'h0100);
        v0 = valid_cnt;
        start_enable();
        for (int i = 0; i < 1300 && valid_cnt == v0; i++) tick();
        chk("rerun_seen",  valid_cnt,       v0 + 1);
        chk("rerun_cycle", last_valid_cyc,  549);
        chk("rerun_data",  last_valid_data, 16'h0100);
        bus.enable = 1'b0;
        wait_idle("rerun_idle");

        chk("valid_never_double", double_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
